rca_sweep_checker: RTL
======================

Name: rca_sweep_checker

Overview:
- Synthesizable exhaustive checker for the ripple-carry adder (RCA) under test.
- Drives every (A, B) operand pair into the adder and samples its {Co, Su} result.
- Compares each result against a reference sum, then reports the pass/fail verdict, error count and first failing vector.
- Sits at the opposite end of the RCA interface from the adder and replaces the open-loop stimulus module in on-board self-test.

Parameters:
- WIDTH, 4: operand width in bits; A, B and Su are WIDTH bits wide.
- SETTLE, 2: number of idle cycles between driving operands and sampling the result (minimum 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- A  output  WIDTH  adder operand A, registered.
- B  output  WIDTH  adder operand B, registered.
- Su  input  WIDTH  adder sum from the RCA.
- Co  input  1  adder carry-out from the RCA.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high in DONE; held until the next start or reset.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  2*WIDTH+1  number of mismatching vectors.
- fail_valid  output  1  at least one mismatch captured this sweep.
- fail_a  output  WIDTH  A of the first mismatching vector.
- fail_b  output  WIDTH  B of the first mismatching vector.

Behaviour:
- Reset (rst_n=0 at a clock edge, from any state):
  - state goes to IDLE.
  - A, B, idx, err_count, fail_a, fail_b all 0.
  - busy, done, pass, fail_valid all 0.
- Vector index idx is 2*WIDTH bits wide, with A = idx[2W-1:W] and B = idx[W-1:0]. A is the outer loop and B the inner loop: the sequence is (0,0), (0,1) … (0,15), (1,0) … (15,15).
- States:
  - IDLE:
    - On start=1: idx←0, A←0, B←0, err_count←0, fail_valid←0, fail_a←0, fail_b←0, settle counter←SETTLE-1, busy←1, go to WAIT.
    - Otherwise hold.
  - WAIT:
    - Decrement the settle counter.
    - When it is 0, go to CHECK. This gives SETTLE cycles in WAIT.
  - CHECK: compare the reference {1'b0,A}+{1'b0,B} (WIDTH+1 bits) with {Co,Su}.
    - On mismatch: err_count+1. If fail_valid=0, capture fail_a←A, fail_b←B and set fail_valid←1.
    - If idx is all ones: busy←0, done←1, go to DONE.
    - Otherwise: idx+1, drive the new A/B, reload the settle counter, go to WAIT.
  - DONE:
    - Hold all results.
    - pass = (err_count==0), driven combinationally from the registers and qualified by done.
    - On start=1: clear everything exactly as in IDLE (done←0) and begin a new sweep.
- Timing:
  - Each vector costs SETTLE+1 cycles.
  - With WIDTH=4 and SETTLE=2: done=1 exactly 768 cycles after the edge that samples start.
  - A/B change only on the edge leaving IDLE, DONE or CHECK, and stay stable through WAIT and CHECK.
- Boundary conditions:
  - start is ignored while busy=1.
  - Reset mid-sweep aborts immediately; no partial results are retained.
  - err_count cannot overflow, because its maximum is 2^(2W) and it is 2W+1 bits wide.
  - The comparison uses the full WIDTH+1 bits, so carry errors and sum errors are both counted.

Optional Feature:
- Macro: RCA_CHK_STOP_ON_FAIL_EN.
- Defined:
  - The CHECK state goes to DONE on the first mismatch.
  - err_count is 1 at that point, and A/B remain at the failing vector for probing.
- Undefined:
  - The full sweep always runs.
  - err_count is the total mismatch count.

Test Plan:
- Correct behavioural adder, start pulsed once → busy for 768 cycles; done=1, pass=1, err_count=0, fail_valid=0.
- Co stuck at 0 → err_count=120, fail_valid=1, fail_a=1, fail_b=15, pass=0.
- Su[0] inverted → err_count=256, fail_a=0, fail_b=0.
- rst_n=0 for 1 cycle at cycle 300 of a sweep → next edge gives IDLE with every output 0. A following start produces a clean sweep with results identical to the first case.
- start re-pulsed while busy=1 at cycle 100 → ignored, done still at cycle 768. start pulsed in DONE → done clears the next cycle and a new 768-cycle sweep runs.
- With RCA_CHK_STOP_ON_FAIL_EN defined and Co stuck at 0 → done after 32*3=96 cycles; err_count=1, A=1, B=15, fail_a=1, fail_b=15.

Source files
------------

// File: rtl/rca_sweep_checker_if.sv
// Operand/result bus between the sweep checker (master) and the ripple-carry adder under test (slave).
interface rca_sweep_checker_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] su;
    logic             co;

    modport master (output a, output b, input su, input co);
    modport slave  (input a, input b, output su, output co);
endinterface

// File: rtl/rca_sweep_checker.sv
// Exhaustive self-test checker for a ripple-carry adder: sweeps every (A,B) pair and scores {Co,Su}.
// Optional macro RCA_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch and parks A/B there.
module rca_sweep_checker #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    rca_sweep_checker_if.master  bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [2*WIDTH:0]     o_err_count,
    output logic                 o_fail_valid,
    output logic [WIDTH-1:0]     o_fail_a,
    output logic [WIDTH-1:0]     o_fail_b
);
    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned EW = 2 * WIDTH + 1;
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state, w_state;
    logic [IW-1:0]   r_idx, w_idx;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [EW-1:0]   r_err, w_err;
    logic            r_fv, w_fv;
    logic [WIDTH-1:0] r_fa, w_fa;
    logic [WIDTH-1:0] r_fb, w_fb;
    logic            r_busy, w_busy;
    logic            r_done, w_done;

    logic [WIDTH:0]  w_ref;
    logic            w_mismatch;
    logic            w_last;
    logic            w_stop;

    // Reference sum is computed from the registered operands, which are stable through WAIT/CHECK.
    assign w_ref      = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_mismatch = (w_ref != {bus.co, bus.su});
    assign w_last     = &r_idx;
`ifdef RCA_CHK_STOP_ON_FAIL_EN
    assign w_stop     = w_last | w_mismatch;
`else
    assign w_stop     = w_last;
`endif

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_err   = r_err;
        w_fv    = r_fv;
        w_fa    = r_fa;
        w_fb    = r_fb;
        w_busy  = r_busy;
        w_done  = r_done;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_idx   = '0;
                    w_err   = '0;
                    w_fv    = 1'b0;
                    w_fa    = '0;
                    w_fb    = '0;
                    w_cnt   = CW'(SETTLE - 1);
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state = ST_CHECK;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            ST_CHECK: begin
                if (w_mismatch) begin
                    w_err = r_err + EW'(1);
                    if (!r_fv) begin
                        w_fv = 1'b1;
                        w_fa = bus.a;
                        w_fb = bus.b;
                    end
                end
                if (w_stop) begin
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = ST_DONE;
                end else begin
                    w_idx   = r_idx + IW'(1);
                    w_cnt   = CW'(SETTLE - 1);
                    w_state = ST_WAIT;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_fv    <= 1'b0;
            r_fa    <= '0;
            r_fb    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_err   <= w_err;
            r_fv    <= w_fv;
            r_fa    <= w_fa;
            r_fb    <= w_fb;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // A is the outer loop (upper half of idx), B the inner loop.
    assign bus.a        = r_idx[IW-1:WIDTH];
    assign bus.b        = r_idx[WIDTH-1:0];
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_done & (r_err == '0);
    assign o_err_count  = r_err;
    assign o_fail_valid = r_fv;
    assign o_fail_a     = r_fa;
    assign o_fail_b     = r_fb;
endmodule
